os_cache_sequencer: RTL and testbench

Control FSM that sits directly upstream of the output-stationary cache and drives its state code, addresses and ready/clear line. One job runs in this order:
- clear the cache;
- load N weights, then N activations, from the bus;
- stream the weight/activation pairs to the PE array;
- load M psums from the GLB;
- drain the M psums to the bus.

Per-beat valid/ready handshakes connect it to the bus, the PE array and the downstream bus consumer.

---
 rtl/os_cache_sequencer.sv | 170 +++++++++++++++++
 tb/tb_os_cache_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/os_cache_sequencer.sv
// Job sequencer for the output-stationary cache: clear, load weights/activations,
// stream pairs to the PE array, load psums from the GLB, drain psums downstream.
module os_cache_sequencer #(
  parameter int ADDR_BITS = 8,
  parameter int WA_ROWS   = 256,
  parameter int P_ROWS    = 32
) (
  input  logic                 w_clk,
  input  logic                 w_rst_n,
  input  logic                 w_start,
  input  logic                 w_abort,
  input  logic [ADDR_BITS-1:0] w_n_wa,
  input  logic [ADDR_BITS-1:0] w_n_p,
  input  logic                 w_bus_valid,
  input  logic                 w_glb_valid,
  input  logic                 w_pe_ready,
  input  logic                 w_out_ready,
  output logic                 r_cache_ready,
  output logic [2:0]           r_state,
  output logic [ADDR_BITS-1:0] r_w_addr,
  output logic [ADDR_BITS-1:0] r_a_addr,
  output logic                 r_bus_accept,
  output logic                 r_glb_accept,
  output logic                 r_pair_valid,
  output logic                 r_psum_valid,
  output logic                 r_busy,
  output logic                 r_done
);

  localparam logic [ADDR_BITS-1:0] N_MAX = ADDR_BITS'(WA_ROWS - 1);
  localparam logic [ADDR_BITS-1:0] P_MAX = ADDR_BITS'(P_ROWS - 1);

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_LW  = 3'b000;
  localparam logic [2:0] C_LA  = 3'b001;
  localparam logic [2:0] C_STR = 3'b100;
  localparam logic [2:0] C_LP  = 3'b101;
  localparam logic [2:0] C_DR  = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD_W, S_LOAD_A, S_STREAM, S_LOAD_P, S_DRAIN, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d, n_q, n_d, m_q, m_d;
  logic                 cache_ready_q, cache_ready_d;
  logic [2:0]           code_q, code_d;
  logic [ADDR_BITS-1:0] waddr_q, waddr_d, aaddr_q, aaddr_d;
  logic                 bus_acc_q, bus_acc_d, glb_acc_q, glb_acc_d;
  logic                 pair_v_q, psum_v_q, busy_q, done_q, done_d;
  logic                 last_wa, last_p;

  assign last_wa = (cnt_q == n_q);
  assign last_p  = (cnt_q == m_q);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    n_d           = n_q;
    m_d           = m_q;
    cache_ready_d = 1'b1;
    code_d        = C_NOP;
    waddr_d       = '0;
    aaddr_d       = '0;
    bus_acc_d     = 1'b0;
    glb_acc_d     = 1'b0;
    done_d        = 1'b0;
    if (w_abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (w_start) begin
          n_d           = (w_n_wa > N_MAX) ? N_MAX : w_n_wa;
          m_d           = (w_n_p > P_MAX) ? P_MAX : w_n_p;
          cache_ready_d = 1'b0;
          state_d       = S_CLEAR;
        end
        S_CLEAR: begin
          cnt_d   = '0;
          state_d = S_LOAD_W;
        end
        S_LOAD_W, S_LOAD_A: if (w_bus_valid) begin
          bus_acc_d = 1'b1;
          if (state_q == S_LOAD_W) begin
            code_d  = C_LW;
            waddr_d = cnt_q;
          end else begin
            code_d  = C_LA;
            aaddr_d = cnt_q;
          end
          cnt_d = last_wa ? '0 : cnt_q + 1'b1;
          if (last_wa) state_d = (state_q == S_LOAD_W) ? S_LOAD_A : S_STREAM;
        end
        S_STREAM: if (w_pe_ready) begin
          code_d  = C_STR;
          waddr_d = cnt_q;
          aaddr_d = cnt_q;
          cnt_d   = last_wa ? '0 : cnt_q + 1'b1;
          if (last_wa) state_d = S_LOAD_P;
        end
        S_LOAD_P: if (w_glb_valid) begin
          code_d    = C_LP;
          waddr_d   = cnt_q;
          glb_acc_d = 1'b1;
          cnt_d     = last_p ? '0 : cnt_q + 1'b1;
          if (last_p) state_d = S_DRAIN;
        end
        S_DRAIN: if (w_out_ready) begin
          code_d  = C_DR;
          waddr_d = cnt_q;
          cnt_d   = last_p ? '0 : cnt_q + 1'b1;
          if (last_p) state_d = S_DONE;
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      n_q           <= '0;
      m_q           <= '0;
      cache_ready_q <= 1'b0;
      code_q        <= C_NOP;
      waddr_q       <= '0;
      aaddr_q       <= '0;
      bus_acc_q     <= 1'b0;
      glb_acc_q     <= 1'b0;
      pair_v_q      <= 1'b0;
      psum_v_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      n_q           <= n_d;
      m_q           <= m_d;
      cache_ready_q <= cache_ready_d;
      code_q        <= code_d;
      waddr_q       <= waddr_d;
      aaddr_q       <= aaddr_d;
      bus_acc_q     <= bus_acc_d;
      glb_acc_q     <= glb_acc_d;
      // Cache outputs are registered: valid trails the issued code by one cycle, even across abort.
      pair_v_q      <= (code_q == C_STR);
      psum_v_q      <= (code_q == C_DR);
      busy_q        <= (state_d != S_IDLE);
      done_q        <= done_d;
    end
  end

  assign r_cache_ready = cache_ready_q;
  assign r_state       = code_q;
  assign r_w_addr      = waddr_q;
  assign r_a_addr      = aaddr_q;
  assign r_bus_accept  = bus_acc_q;
  assign r_glb_accept  = glb_acc_q;
  assign r_pair_valid  = pair_v_q;
  assign r_psum_valid  = psum_v_q;
  assign r_busy        = busy_q;
  assign r_done        = done_q;

endmodule

// File: tb/tb_os_cache_sequencer.sv
// Bench for os_cache_sequencer: directed job scenarios plus random traffic,
// checked every cycle against a phase-table reference model.
module tb_os_cache_sequencer;
  localparam int PR = 32;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, abort, bus_v, glb_v, pe_r, out_r;
  logic [7:0] n_wa, n_p;
  logic       cache_ready, bus_acc, glb_acc, pair_v, psum_v, busy, done;
  logic [2:0] st;
  logic [7:0] waddr, aaddr;

  os_cache_sequencer dut (
    .w_clk(clk), .w_rst_n(rst_n), .w_start(start), .w_abort(abort),
    .w_n_wa(n_wa), .w_n_p(n_p), .w_bus_valid(bus_v), .w_glb_valid(glb_v),
    .w_pe_ready(pe_r), .w_out_ready(out_r), .r_cache_ready(cache_ready),
    .r_state(st), .r_w_addr(waddr), .r_a_addr(aaddr), .r_bus_accept(bus_acc),
    .r_glb_accept(glb_acc), .r_pair_valid(pair_v), .r_psum_valid(psum_v),
    .r_busy(busy), .r_done(done)
  );

  int compared = 0, mismatched = 0;

  // Reference model: job = list of phases, each a number of beats gated by one input.
  int         ph, cnt, nn, mm, e_addr;
  logic       e_ready, e_bus, e_glb, e_pv, e_qv, e_busy, e_done;
  logic [2:0] e_st;

  // Per-job statistics and issue log
  int         cyc, n_bus, n_glb, n_pv, n_qv, n_done, done_cyc;
  logic [2:0] st_log[$];
  int         ad_log[$];

  function automatic void chk(string tag, logic [31:0] act, logic [31:0] exp);
    compared++;
    assert (act === exp) else begin
      mismatched++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, act, exp);
    end
  endfunction

  function automatic logic [2:0] phase_code(int p);
    case (p)
      2: return 3'b000;
      3: return 3'b001;
      4: return 3'b100;
      5: return 3'b101;
      default: return 3'b110;
    endcase
  endfunction

  task automatic model_step();
    logic go;
    if (!rst_n) begin
      ph = 0; cnt = 0; e_ready = 0; e_st = 3'b111; e_bus = 0; e_glb = 0;
      e_pv = 0; e_qv = 0; e_busy = 0; e_done = 0;
      return;
    end
    e_pv = (e_st == 3'b100);
    e_qv = (e_st == 3'b110);
    e_st = 3'b111; e_bus = 0; e_glb = 0; e_done = 0; e_ready = 1;
    if (abort) ph = 0;
    else if (ph == 0) begin
      if (start) begin
        nn = int'(n_wa) + 1;
        mm = ((n_p > PR - 1) ? PR - 1 : int'(n_p)) + 1;
        ph = 1; e_ready = 0;
      end
    end else if (ph == 1) begin ph = 2; cnt = 0; end
    else if (ph == 7) begin e_done = 1; ph = 0; end
    else begin
      go = (ph <= 3) ? bus_v : (ph == 4) ? pe_r : (ph == 5) ? glb_v : out_r;
      if (go) begin
        e_st = phase_code(ph); e_addr = cnt;
        e_bus = (ph <= 3); e_glb = (ph == 5);
        cnt++;
        if (cnt == ((ph <= 4) ? nn : mm)) begin cnt = 0; ph++; end
      end
    end
    e_busy = (ph != 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    chk("cache_ready", cache_ready, e_ready);
    chk("state", st, e_st);
    chk("bus_accept", bus_acc, e_bus);
    chk("glb_accept", glb_acc, e_glb);
    chk("pair_valid", pair_v, e_pv);
    chk("psum_valid", psum_v, e_qv);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    if (e_st inside {3'b000, 3'b100, 3'b101, 3'b110}) chk("w_addr", waddr, e_addr);
    if (e_st inside {3'b001, 3'b100}) chk("a_addr", aaddr, e_addr);
    if (bus_acc) n_bus++;
    if (glb_acc) n_glb++;
    if (pair_v) n_pv++;
    if (psum_v) n_qv++;
    if (done) begin n_done++; done_cyc = cyc; end
    if (st != 3'b111) begin
      st_log.push_back(st);
      ad_log.push_back((st == 3'b001) ? int'(aaddr) : int'(waddr));
    end
  endtask

  task automatic clr_stats();
    cyc = 0; n_bus = 0; n_glb = 0; n_pv = 0; n_qv = 0; n_done = 0; done_cyc = -1;
    st_log.delete(); ad_log.delete();
  endtask

  task automatic all_ready();
    bus_v = 1; glb_v = 1; pe_r = 1; out_r = 1;
  endtask

  // mode 0: all ready, 1: bus valid toggles, 2: random, 3: PE stall after pair 1
  task automatic run_job(int mode, int budget);
    int stall = 0;
    bit stalled = 0;
    clr_stats();
    all_ready();
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < budget && n_done == 0; i++) begin
      if (mode == 1) bus_v = ~bus_v;
      if (mode == 2) begin
        bus_v = ($urandom_range(0, 2) != 0); glb_v = ($urandom_range(0, 2) != 0);
        pe_r  = ($urandom_range(0, 2) != 0); out_r = ($urandom_range(0, 2) != 0);
      end
      if (mode == 3) begin
        pe_r = (stall > 0) ? 1'b0 : 1'b1;
        if (stall > 0) stall--;
      end
      tick();
      if (mode == 3 && st == 3'b100 && waddr == 8'd1 && !stalled) begin
        stall = 2; stalled = 1;
      end
    end
    chk("job_done_seen", n_done, 1);
    all_ready();
  endtask

  // The k-th issue of a given code must carry address k, and there must be len of them.
  task automatic chk_phase(string tag, logic [2:0] code, int len);
    int k = 0;
    for (int i = 0; i < st_log.size(); i++)
      if (st_log[i] == code) begin
        chk(tag, ad_log[i], k);
        k++;
      end
    chk({tag, "_count"}, k, len);
  endtask

  initial begin
    logic [2:0] exp_seq[$];
    logic       pv_seq[$];
    bit         seen;
    clr_stats();
    rst_n = 0; start = 0; abort = 0; n_wa = 3; n_p = 1;
    all_ready();
    tick(); tick();
    chk("rst_state", st, 3'b111);
    chk("rst_cache_ready", cache_ready, 0);
    rst_n = 1;
    tick();
    chk("idle_cache_ready", cache_ready, 1);

    // Basic job N=4, M=2
    run_job(0, 60);
    chk("basic_done_cycle", done_cyc, 19);
    for (int i = 0; i < 4; i++) exp_seq.push_back(3'b000);
    for (int i = 0; i < 4; i++) exp_seq.push_back(3'b001);
    for (int i = 0; i < 4; i++) exp_seq.push_back(3'b100);
    for (int i = 0; i < 2; i++) exp_seq.push_back(3'b101);
    for (int i = 0; i < 2; i++) exp_seq.push_back(3'b110);
    chk("basic_issue_count", st_log.size(), 16);
    for (int i = 0; i < 16 && i < st_log.size(); i++) chk("basic_seq", st_log[i], exp_seq[i]);
    chk_phase("basic_w", 3'b000, 4);
    chk_phase("basic_p", 3'b101, 2);
    chk("basic_bus_acc", n_bus, 8);
    chk("basic_glb_acc", n_glb, 2);
    tick();

    // Bus valid toggling
    run_job(1, 80);
    chk_phase("tog_w", 3'b000, 4);
    chk_phase("tog_a", 3'b001, 4);
    chk("tog_bus_acc", n_bus, 8);

    // PE stall after pair 1
    run_job(3, 80);
    chk_phase("stall_s", 3'b100, 4);
    seen = 0;
    pv_seq.delete();
    clr_stats();
    n_wa = 3; n_p = 1;
    begin
      int stall = 0;
      bit stalled = 0;
      start = 1; tick(); start = 0;
      for (int i = 0; i < 80 && n_done == 0; i++) begin
        pe_r = (stall > 0) ? 1'b0 : 1'b1;
        if (stall > 0) stall--;
        tick();
        if (pair_v) seen = 1;
        if (seen && pv_seq.size() < 6) pv_seq.push_back(pair_v);
        if (st == 3'b100 && waddr == 8'd1 && !stalled) begin stall = 2; stalled = 1; end
      end
      chk("stall_pv_len", pv_seq.size(), 6);
      for (int i = 0; i < 6 && i < pv_seq.size(); i++)
        chk("stall_pv_pattern", pv_seq[i], (i == 2 || i == 3) ? 0 : 1);
    end
    all_ready();

    // Psum count saturation
    n_wa = 2; n_p = 40;
    run_job(0, 200);
    chk_phase("sat_drain", 3'b110, 32);
    chk("sat_psum_valid", n_qv, 32);

    // Single-beat phases and the largest N
    n_wa = 0; n_p = 0;
    run_job(0, 40);
    chk("min_done_cycle", done_cyc, 8);
    n_wa = 255; n_p = 0;
    run_job(0, 900);
    chk_phase("max_w", 3'b000, 256);
    chk_phase("max_s", 3'b100, 256);
    chk("max_done_cycle", done_cyc, 773);

    // Abort when LOAD_P beat 0 would issue, then a clean job
    n_wa = 3; n_p = 1;
    clr_stats();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 40 && !(st == 3'b100 && waddr == 8'd3); i++) tick();
    abort = 1;
    tick();
    abort = 0;
    chk("abort_state", st, 3'b111);
    chk("abort_glb_acc", glb_acc, 0);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("abort_no_done", n_done, 0);
    run_job(0, 60);
    chk("after_abort_done_cycle", done_cyc, 19);

    // start and abort together in IDLE
    start = 1; abort = 1; tick(); start = 0; abort = 0;
    chk("start_abort_busy", busy, 0);
    tick();

    // Reset mid-STREAM
    clr_stats();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 40 && st != 3'b100; i++) tick();
    chk("reached_stream", st, 3'b100);
    rst_n = 0;
    tick();
    chk("midrst_state", st, 3'b111);
    chk("midrst_cache_ready", cache_ready, 0);
    chk("midrst_busy", busy, 0);
    tick(); tick();
    rst_n = 1;
    clr_stats();
    tick();
    chk("postrst_cache_ready", cache_ready, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("postrst_no_issue", st_log.size(), 0);

    // Random traffic including ignored starts, aborts and rare resets
    run_job(2, 400);
    for (int i = 0; i < 4000; i++) begin
      bus_v = ($urandom_range(0, 3) != 0); glb_v = ($urandom_range(0, 3) != 0);
      pe_r  = ($urandom_range(0, 3) != 0); out_r = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 149) == 0);
      rst_n = ($urandom_range(0, 799) != 0);
      n_wa  = 8'($urandom_range(0, 12));
      n_p   = 8'($urandom_range(0, 40));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
